// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the multiply/divide sequencer: issue opcode, FSM states, helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package pipTypes;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_MUL  = 3'd1,
      OP_DIV  = 3'd2,
      OP_MADD = 3'd3,
      OP_MFHI = 3'd4,
      OP_MFLO = 3'd5,
      OP_MTHI = 3'd6,
      OP_MTLO = 3'd7
   } muldiv_op_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL  = 3'd1,
      DIV  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_t;

   // Magnitude of a 32-bit operand; unsigned operands are already magnitudes.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic uns);
      return (!uns && v[31]) ? -v : v;
   endfunction

   // Ops whose result becomes the new architectural HI/LO pair.
   function automatic logic writes_hilo(input muldiv_op_t op);
      return (op == OP_MUL) || (op == OP_MADD) || (op == OP_DIV) ||
             (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
// Latency: DIV_CYCLES cycles after i_start; o_done marks the cycle whose edge retires the last bit.
// Backpressure: none; a new i_start restarts it, i_abort idles it.
module div_iter #(
   parameter int DIV_CYCLES = 32
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem,
   output logic        o_done
);
   localparam int            CW   = $clog2(DIV_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

   logic [31:0]   r_quot;
   logic [31:0]   r_rem;
   logic [31:0]   r_dvs;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [32:0]   w_shift;
   logic [32:0]   w_diff;

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   assign w_shift = {r_rem, r_quot[31]};
   assign w_diff  = w_shift - {1'b0, r_dvs};

   assign o_quot = r_quot;
   assign o_rem  = r_rem;
   assign o_done = r_busy && (r_cnt == LAST);

   // One iteration per cycle; the quotient shifts in where the dividend shifts out.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_quot <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_quot <= i_dividend;
         r_rem  <= '0;
         r_dvs  <= i_divisor;
         r_cnt  <= '0;
         r_busy <= 1'b1;
      end else if (i_abort) begin
         r_busy <= 1'b0;
      end else if (r_busy) begin
         r_quot <= {r_quot[30:0], ~w_diff[32]};
         r_rem  <= w_diff[32] ? w_shift[31:0] : w_diff[31:0];
         r_cnt  <= r_cnt + 1'b1;
         if (r_cnt == LAST) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO; one op in flight, result tagged with ROB index.
// Latency: MF*/MT* 1, MUL/MADD MUL_LATENCY, DIV DIV_CYCLES+2 (3 on early-out when MULDIV_EARLY_OUT_EN is defined).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts anywhere.
module muldiv_ctrl
   import pipTypes::*;
#(
   parameter int MUL_LATENCY = 2,
   parameter int DIV_CYCLES  = 32,
   parameter int ROB_IDX_W   = 4
)(
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  muldiv_op_t           in_op,
   input  logic                 in_unsigned,
   input  logic [31:0]          in_a,
   input  logic [31:0]          in_b,
   input  logic [ROB_IDX_W-1:0] in_rob_idx,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ROB_IDX_W-1:0] out_rob_idx,
   output logic [31:0]          out_result_hi,
   output logic [31:0]          out_result_lo,
   output logic                 busy
);
   localparam int         PIPE_N   = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
   localparam logic [7:0] MUL_LAST = 8'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

   muldiv_state_t          r_state;
   muldiv_state_t          w_next;
   muldiv_op_t             r_op;
   logic [ROB_IDX_W-1:0]   r_rob;
   logic [31:0]            r_a;
   logic                   r_a_neg;
   logic                   r_b_neg;
   logic                   r_b_zero;
   logic [7:0]             r_mul_cnt;
   logic [63:0]            r_pipe [PIPE_N];
   logic [31:0]            r_hi;
   logic [31:0]            r_lo;
   logic [31:0]            r_res_hi;
   logic [31:0]            r_res_lo;
`ifdef MULDIV_EARLY_OUT_EN
   logic                   r_early;
   logic [31:0]            r_a_mag;
`endif

   logic                   w_accept;
   logic                   w_is_mul_op;
   logic [63:0]            w_a_ext;
   logic [63:0]            w_b_ext;
   logic [63:0]            w_prod;
   logic [63:0]            w_mul_src;
   logic                   w_mul_acc;
   logic [63:0]            w_mul_res;
   logic [31:0]            w_a_mag;
   logic [31:0]            w_b_mag;
   logic [31:0]            w_quot;
   logic [31:0]            w_rem;
   logic                   w_div_done;
   logic [31:0]            w_q_mag;
   logic [31:0]            w_r_mag;
   logic [31:0]            w_fix_hi;
   logic [31:0]            w_fix_lo;
   logic                   w_commit;

   assign in_ready      = (r_state == IDLE) & ~flush;
   assign w_accept      = in_valid & in_ready & (in_op != OP_NONE);
   assign w_is_mul_op   = (in_op == OP_MUL) || (in_op == OP_MADD);
   assign out_valid     = (r_state == DONE);
   assign busy          = (r_state != IDLE);
   assign out_rob_idx   = r_rob;
   assign out_result_hi = r_res_hi;
   assign out_result_lo = r_res_lo;
   assign w_commit      = out_valid & out_ready & ~flush & writes_hilo(r_op);

   // 64x64 product of extended operands; low 64 bits are exact for both signednesses.
   assign w_a_ext   = in_unsigned ? {32'b0, in_a} : {{32{in_a[31]}}, in_a};
   assign w_b_ext   = in_unsigned ? {32'b0, in_b} : {{32{in_b[31]}}, in_b};
   assign w_prod    = w_a_ext * w_b_ext;
   assign w_mul_src = (MUL_LATENCY == 1) ? w_prod : r_pipe[PIPE_N-1];
   assign w_mul_acc = (r_state == IDLE) ? (in_op == OP_MADD) : (r_op == OP_MADD);
   assign w_mul_res = w_mul_acc ? ({r_hi, r_lo} + w_mul_src) : w_mul_src;

   assign w_a_mag = mag32(in_a, in_unsigned);
   assign w_b_mag = mag32(in_b, in_unsigned);

   div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div_iter (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_start    (w_accept && (in_op == OP_DIV)),
      .i_abort    (flush),
      .i_dividend (w_a_mag),
      .i_divisor  (w_b_mag),
      .o_quot     (w_quot),
      .o_rem      (w_rem),
      .o_done     (w_div_done)
   );

   // Sign-correct the divider magnitudes; divide-by-zero returns all-ones / dividend.
   always_comb begin
      w_q_mag = w_quot;
      w_r_mag = w_rem;
`ifdef MULDIV_EARLY_OUT_EN
      if (r_early) begin
         w_q_mag = '0;
         w_r_mag = r_a_mag;
      end
`endif
      if (r_b_zero) begin
         w_fix_lo = '1;
         w_fix_hi = r_a;
      end else begin
         w_fix_lo = (r_a_neg ^ r_b_neg) ? -w_q_mag : w_q_mag;
         w_fix_hi = r_a_neg ? -w_r_mag : w_r_mag;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic; flush overrides everything and returns to IDLE.
   always_comb begin
      w_next = r_state;
      if (flush) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (w_accept) begin
               if (w_is_mul_op)          w_next = (MUL_LATENCY == 1) ? DONE : MUL;
               else if (in_op == OP_DIV) w_next = DIV;
               else                      w_next = DONE;
            end
            MUL:  if (r_mul_cnt == MUL_LAST) w_next = DONE;
`ifdef MULDIV_EARLY_OUT_EN
            DIV:  if (r_early || w_div_done) w_next = FIX;
`else
            DIV:  if (w_div_done) w_next = FIX;
`endif
            FIX:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
         endcase
      end
   end

   // Operand capture, multiplier retiming stages and the held result register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_op      <= OP_NONE;
         r_rob     <= '0;
         r_a       <= '0;
         r_a_neg   <= 1'b0;
         r_b_neg   <= 1'b0;
         r_b_zero  <= 1'b0;
         r_mul_cnt <= '0;
         r_res_hi  <= '0;
         r_res_lo  <= '0;
         for (int k = 0; k < PIPE_N; k++) r_pipe[k] <= '0;
`ifdef MULDIV_EARLY_OUT_EN
         r_early   <= 1'b0;
         r_a_mag   <= '0;
`endif
      end else begin
         for (int k = 1; k < PIPE_N; k++) r_pipe[k] <= r_pipe[k-1];
         if (w_accept) begin
            r_op      <= in_op;
            r_rob     <= in_rob_idx;
            r_a       <= in_a;
            r_a_neg   <= ~in_unsigned & in_a[31];
            r_b_neg   <= ~in_unsigned & in_b[31];
            r_b_zero  <= (in_b == 32'd0);
            r_mul_cnt <= '0;
            r_pipe[0] <= w_prod;
`ifdef MULDIV_EARLY_OUT_EN
            r_early   <= (in_b == 32'd0) || (w_a_mag < w_b_mag);
            r_a_mag   <= w_a_mag;
`endif
         end else if (r_state == MUL) begin
            r_mul_cnt <= r_mul_cnt + 1'b1;
         end
         if ((w_next == DONE) && (r_state != DONE)) begin
            if (r_state == FIX) begin
               {r_res_hi, r_res_lo} <= {w_fix_hi, w_fix_lo};
            end else if ((r_state == MUL) || w_is_mul_op) begin
               {r_res_hi, r_res_lo} <= w_mul_res;
            end else begin
               case (in_op)
                  OP_MFHI: {r_res_hi, r_res_lo} <= {32'd0, r_hi};
                  OP_MFLO: {r_res_hi, r_res_lo} <= {32'd0, r_lo};
                  OP_MTHI: {r_res_hi, r_res_lo} <= {in_a, r_lo};
                  OP_MTLO: {r_res_hi, r_res_lo} <= {r_hi, in_a};
                  default: {r_res_hi, r_res_lo} <= {r_res_hi, r_res_lo};
               endcase
            end
         end
      end
   end

   // Architectural HI/LO: updated only when the ROB takes a writing result.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_commit) begin
         r_hi <= r_res_hi;
         r_lo <= r_res_lo;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomised and directed scoreboard bench for muldiv_ctrl.
// Expected results come from a plain-arithmetic HI/LO model; a monitor compares every valid cycle.
// out_ready is randomised, forced low or high per phase.
module tb_muldiv_ctrl;
   import pipTypes::*;

   localparam int MUL_LAT = 2;
   localparam int DIV_CYC = 32;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   muldiv_op_t  in_op = OP_NONE;
   logic        in_unsigned = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_rob_idx = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_rob_idx;
   logic [31:0] out_result_hi;
   logic [31:0] out_result_lo;
   logic        busy;

   muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_CYCLES(DIV_CYC), .ROB_IDX_W(4)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_unsigned(in_unsigned),
      .in_a(in_a), .in_b(in_b), .in_rob_idx(in_rob_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_rob_idx(out_rob_idx),
      .out_result_hi(out_result_hi), .out_result_lo(out_result_lo), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  rob;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          acc;
      bit          seen;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          rdy_mode = 0;    // 0 random, 1 held low, 2 held high
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [3:0]  next_rob = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference result straight from the architectural definition.
   function automatic logic [63:0] ref_result(input muldiv_op_t op, input bit uns,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] prod;
      longint      sa, sb, sq, sr;
      logic [63:0] uq, ur;
      if (uns) prod = 64'(a) * 64'(b);
      else     prod = 64'(longint'($signed(a)) * longint'($signed(b)));
      case (op)
         OP_MUL:  return prod;
         OP_MADD: return {hi, lo} + prod;
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (uns) begin
               uq = 64'(a) / 64'(b);
               ur = 64'(a) % 64'(b);
               return {ur[31:0], uq[31:0]};
            end
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         OP_MFHI: return {32'd0, hi};
         OP_MFLO: return {32'd0, lo};
         OP_MTHI: return {a, lo};
         OP_MTLO: return {hi, a};
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_latency(input muldiv_op_t op, input bit uns,
                                      input logic [31:0] a, input logic [31:0] b);
      longint ma, mb;
      ma = uns ? longint'(a) : ((a[31]) ? -longint'($signed(a)) : longint'(a));
      mb = uns ? longint'(b) : ((b[31]) ? -longint'($signed(b)) : longint'(b));
      if (op == OP_MUL || op == OP_MADD) return MUL_LAT;
      if (op == OP_DIV) begin
`ifdef MULDIV_EARLY_OUT_EN
         if (b == 32'd0 || ma < mb) return 3;
`endif
         if (ma < 0 || mb < 0) return -1;
         return DIV_CYC + 2;
      end
      return 1;
   endfunction

   // out_ready driver.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: every valid cycle must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n && out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
               e = q[0];
               if (!e.seen) begin
                  chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                  q[0].seen = 1'b1;
               end
               chk("in_ready_while_valid", 64'(in_ready), 64'd0);
               chk("out_rob_idx", 64'(out_rob_idx), 64'(e.rob));
               chk("out_result", {out_result_hi, out_result_lo}, {e.hi, e.lo});
               if (out_ready && !flush) void'(q.pop_front());
            end
         end
      end
   end

   // Present one op until accepted; optionally record its expected result.
   task automatic issue(input muldiv_op_t op, input bit uns, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
      int   acc;
      bit   ok;
      exp_t e;
      logic [63:0] r;
      @(posedge clock);
      #1;
      in_valid = 1'b1; in_op = op; in_unsigned = uns; in_a = a; in_b = b; in_rob_idx = next_rob;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 64'd0, 64'd1);
         in_valid = 1'b0; in_op = OP_NONE;
         return;
      end
      acc = cyc;
      @(posedge clock);
      #1;
      in_valid = 1'b0; in_op = OP_NONE;
      if (push) begin
         r = ref_result(op, uns, a, b, m_hi, m_lo);
         e.rob = next_rob; e.hi = r[63:32]; e.lo = r[31:0];
         e.lat = ref_latency(op, uns, a, b); e.acc = acc; e.seen = 1'b0;
         q.push_back(e);
         if (writes_hilo(op)) begin m_hi = r[63:32]; m_lo = r[31:0]; end
      end
      next_rob = next_rob + 4'd1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 600; i++) begin
         @(negedge clock);
         if (q.size() == 0 && !busy) return;
      end
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
   endtask

   // Global watchdog.
   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      muldiv_op_t op;
      logic [31:0] a, b;
      bit uns;

      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", {out_result_hi, out_result_lo}, 64'd0);
      chk("rst_out_rob", 64'(out_rob_idx), 64'd0);

      // Directed arithmetic cases.
      issue(OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1);
      issue(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b1);
      issue(OP_DIV, 1'b1, 32'd100, 32'd7, 1'b1);
      issue(OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
      issue(OP_DIV, 1'b0, 32'h0000_1234, 32'd0, 1'b1);
      issue(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      issue(OP_DIV, 1'b0, 32'hFFFF_FFFB, 32'd9, 1'b1);
      issue(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1);
      wait_drain();

      // MADD with the ROB stalling the result.
      issue(OP_MTHI, 1'b0, 32'd5, 32'd0, 1'b1);
      issue(OP_MTLO, 1'b0, 32'd7, 32'd0, 1'b1);
      wait_drain();
      rdy_mode = 1;
      @(posedge clock);
      issue(OP_MADD, 1'b1, 32'd2, 32'd3, 1'b1);
      repeat (6) @(negedge clock);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_result", {out_result_hi, out_result_lo}, {32'd5, 32'd13});
      rdy_mode = 0;
      wait_drain();

      // Flush in the middle of a divide.
      issue(OP_DIV, 1'b1, 32'd1000, 32'd3, 1'b0);
      repeat (9) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      chk("flush_busy", 64'(busy), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (40) @(negedge clock);
      issue(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1);
      wait_drain();

      // Reset in the middle of a multiply.
      issue(OP_MUL, 1'b0, 32'd1234, 32'd5678, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      q.delete();
      m_hi = '0; m_lo = '0;
      #1 reset_n = 1'b1;
      @(negedge clock);
      chk("mrst_out_valid", 64'(out_valid), 64'd0);
      chk("mrst_in_ready", 64'(in_ready), 64'd1);
      chk("mrst_busy", 64'(busy), 64'd0);
      issue(OP_MFHI, 1'b0, 32'd0, 32'd0, 1'b1);
      issue(OP_MFLO, 1'b0, 32'd0, 32'd0, 1'b1);
      wait_drain();

      // Random ops; divisors are often small or zero to hit the corner cases.
      for (int n = 0; n < 60; n++) begin
         op  = muldiv_op_t'(3'($urandom_range(1, 7)));
         uns = 1'($urandom_range(0, 1));
         a   = $urandom();
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom();
         endcase
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 15));
         issue(op, uns, a, b, 1'b1);
      end
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
